// File: rtl/sec_sensor_frontend_pkg.sv
// Shared definitions for the security-alarm front end and the alarm FSM it feeds.
//   - Channel index constants for the sensor lines.
//   - Alarm FSM state encodings, kept here so both blocks agree on them.
//   - Small helper for debounced rising-edge detection.
package sec_pkg;

  // Channel roles on the sensor_raw bus
  localparam int CH_ARM  = 0;  // arm key
  localparam int CH_TRIG = 1;  // motion sensor
  localparam int CH_DOOR = 2;  // door / tamper line

  // Alarm FSM state encoding, consumed by the downstream FSM
  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_ALARM_ON  = 2'd3
  } alarm_state_e;

  // True when a level goes from 0 (prev) to 1 (next)
  function automatic logic rise_detect(input logic prev, input logic next);
    return next & ~prev;
  endfunction

endpackage

// File: rtl/sec_sensor_frontend_if.sv
// Bundle of the sensor front-end signals.
//   en          : pulse generation enable (driver -> front end)
//   sensor_raw  : raw asynchronous sensor/key lines (driver -> front end)
//   sens_stable : debounced level per channel (front end -> consumer)
//   arm_pulse / trig_pulse / conf_pulse : single-cycle event pulses (front end -> FSM)
// master = stimulus/consumer side, slave = the front end itself.
interface sec_sensor_frontend_if #(
  parameter int N_CH = 3
) ();

  logic            en;
  logic [N_CH-1:0] sensor_raw;
  logic [N_CH-1:0] sens_stable;
  logic            arm_pulse;
  logic            trig_pulse;
  logic            conf_pulse;

  modport master (
    output en, sensor_raw,
    input  sens_stable, arm_pulse, trig_pulse, conf_pulse
  );

  modport slave (
    input  en, sensor_raw,
    output sens_stable, arm_pulse, trig_pulse, conf_pulse
  );

endinterface

// File: rtl/sec_sensor_frontend_debounce.sv
// One sensor line: 2-FF synchroniser, counter debouncer and registered rising-edge pulse.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw_i       : raw asynchronous line
//   pulse_en_i  : qualifies the rise pulse (sampled together with the stable update)
//   stable_o    : debounced level
//   rise_o      : one-cycle pulse, high in the cycle stable_o goes 0->1
module sec_debounce_ch
  import sec_pkg::*;
#(
  parameter int DEBOUNCE_W   = 8,
  parameter int DEBOUNCE_CNT = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic pulse_en_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [DEBOUNCE_W-1:0] DCNT_LAST = DEBOUNCE_W'(DEBOUNCE_CNT - 1);
  localparam logic [DEBOUNCE_W-1:0] DCNT_ZERO = {DEBOUNCE_W{1'b0}};
  localparam logic [DEBOUNCE_W-1:0] DCNT_ONE  = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  stable_q;
  logic                  stable_d;
  logic                  rise_q;
  logic                  rise_d;
  logic [DEBOUNCE_W-1:0] dcnt_q;
  logic [DEBOUNCE_W-1:0] dcnt_d;

  // Two-stage synchroniser for the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after it persists for DEBOUNCE_CNT cycles
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    if (sync2_q == stable_q) begin
      // Any agreement (including a glitch ending) restarts the persistence count
      dcnt_d = DCNT_ZERO;
    end else if (dcnt_q == DCNT_LAST) begin
      stable_d = sync2_q;
      dcnt_d   = DCNT_ZERO;
    end else begin
      dcnt_d = dcnt_q + DCNT_ONE;
    end
    rise_d = rise_detect(stable_q, stable_d) & pulse_en_i;
  end

  // Debounce state and edge pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      dcnt_q   <= DCNT_ZERO;
      rise_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      rise_q   <= rise_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/sec_sensor_frontend.sv
// Input stage of the security-alarm FSM.
// Conditions N_CH raw sensor lines and produces arm / trigger / confirm pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sec_sensor_frontend_if
//                (en, sensor_raw in; sens_stable, arm_pulse, trig_pulse, conf_pulse out)
// Channels >= CH_DOOR+1 are only debounced and reported on sens_stable.
module sec_sensor_frontend
  import sec_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int DEBOUNCE_W   = 8,
  parameter int DEBOUNCE_CNT = 200,
  parameter int CONFIRM_W    = 16,
  parameter int CONFIRM_CNT  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sec_sensor_frontend_if.slave  bus
);

  localparam logic [CONFIRM_W-1:0] CCNT_LAST = CONFIRM_W'(CONFIRM_CNT - 1);
  localparam logic [CONFIRM_W-1:0] CCNT_ZERO = {CONFIRM_W{1'b0}};
  localparam logic [CONFIRM_W-1:0] CCNT_ONE  = {{(CONFIRM_W-1){1'b0}}, 1'b1};

  logic [N_CH-1:0]      stable_s;
  logic [N_CH-1:0]      rise_s;
  logic                 unused_rise_s;
  logic [CONFIRM_W-1:0] ccnt_q;
  logic [CONFIRM_W-1:0] ccnt_d;
  logic                 fired_q;
  logic                 fired_d;
  logic                 conf_q;
  logic                 conf_d;

  // One conditioning lane per sensor line
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sec_debounce_ch #(
      .DEBOUNCE_W   (DEBOUNCE_W),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_i      (bus.sensor_raw[g]),
      .pulse_en_i (bus.en),
      .stable_o   (stable_s[g]),
      .rise_o     (rise_s[g])
    );
  end

  // Door and auxiliary channels have no edge pulse output
  assign unused_rise_s = ^rise_s[N_CH-1:CH_DOOR];

  // Confirm timer: one pulse per continuous enabled high period of the door line
  always_comb begin
    ccnt_d  = ccnt_q;
    fired_d = fired_q;
    conf_d  = 1'b0;
    if (!bus.en || !stable_s[CH_DOOR]) begin
      ccnt_d  = CCNT_ZERO;
      fired_d = 1'b0;
    end else if (!fired_q && (ccnt_q == CCNT_LAST)) begin
      // Count holds here so it can never wrap while the line stays high
      conf_d  = 1'b1;
      fired_d = 1'b1;
    end else if (!fired_q) begin
      ccnt_d = ccnt_q + CCNT_ONE;
    end else begin
      ccnt_d = ccnt_q;
    end
  end

  // Confirm timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt_q  <= CCNT_ZERO;
      fired_q <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      ccnt_q  <= ccnt_d;
      fired_q <= fired_d;
      conf_q  <= conf_d;
    end
  end

  assign bus.sens_stable = stable_s;
  assign bus.arm_pulse   = rise_s[CH_ARM];
  assign bus.trig_pulse  = rise_s[CH_TRIG];
  assign bus.conf_pulse  = conf_q;

endmodule

// File: tb/tb_sec_sensor_frontend.sv
// Scoreboard bench for sec_sensor_frontend (N_CH=4, DEBOUNCE_CNT=4, CONFIRM_CNT=8).
// The stimulus side pushes the expected post-edge outputs from a reference model;
// a monitor pops and compares one entry after every clock edge.
module tb_sec_sensor_frontend;

  localparam int NCH = 4;
  localparam int DC  = 4;
  localparam int CC  = 8;

  typedef struct packed {
    logic [NCH-1:0] st;
    logic           arm;
    logic           trig;
    logic           conf;
  } exp_t;

  logic clk;
  logic rst_n;

  sec_sensor_frontend_if #(.N_CH(NCH)) bus_if ();

  sec_sensor_frontend #(
    .N_CH         (NCH),
    .DEBOUNCE_W   (8),
    .DEBOUNCE_CNT (DC),
    .CONFIRM_W    (16),
    .CONFIRM_CNT  (CC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  exp_t           exp_q[$];
  logic [NCH-1:0] raw_hist[$];
  logic [NCH-1:0] sync_hist[$];
  logic [NCH-1:0] m_stable = '0;
  int             conf_run = 0;

  // Observed pulse counts, sampled after each edge
  int arm_cnt = 0;
  int trig_cnt = 0;
  int conf_cnt = 0;
  int both_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Spec-level model: a line's level is accepted once its synchronised value has
  // disagreed with the accepted level for the last DC edges in a row; the confirm
  // pulse fires on the CC-th consecutive edge with en and ch2 accepted high.
  task automatic model_step();
    exp_t           e;
    logic [NCH-1:0] s;
    logic [NCH-1:0] nst;
    logic [NCH-1:0] rise;
    bit             flip;
    if (!rst_n) begin
      raw_hist.delete();
      sync_hist.delete();
      m_stable = '0;
      conf_run = 0;
      exp_q.push_back('0);
      return;
    end
    s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
    raw_hist.push_back(bus_if.sensor_raw);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    sync_hist.push_back(s);
    if (sync_hist.size() > DC) void'(sync_hist.pop_front());
    if (bus_if.en && m_stable[2]) conf_run++;
    else conf_run = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      flip = (sync_hist.size() == DC);
      for (int i = 0; i < sync_hist.size(); i++)
        if (sync_hist[i][ch] == m_stable[ch]) flip = 0;
      nst[ch] = flip ? ~m_stable[ch] : m_stable[ch];
    end
    rise   = nst & ~m_stable;
    e.st   = nst;
    e.arm  = rise[0] & bus_if.en;
    e.trig = rise[1] & bus_if.en;
    e.conf = (conf_run == CC);
    exp_q.push_back(e);
    m_stable = nst;
  endtask

  // Advance one clock edge with the inputs currently applied
  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    if (bus_if.arm_pulse) arm_cnt++;
    if (bus_if.trig_pulse) trig_cnt++;
    if (bus_if.conf_pulse) conf_cnt++;
    if (bus_if.arm_pulse && bus_if.trig_pulse) both_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges and check outputs clear without a clock edge
  task automatic async_reset_check(input string name);
    rst_n = 1'b0;
    #1;
    chk(name, {bus_if.sens_stable, bus_if.arm_pulse, bus_if.trig_pulse, bus_if.conf_pulse}, 32'd0);
  endtask

  // Monitor: compare the DUT against the next scoreboard entry after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle_outputs",
            {bus_if.sens_stable, bus_if.arm_pulse, bus_if.trig_pulse, bus_if.conf_pulse}, e);
      end
    end
  end

  int a0, t0, c0, b0;
  int hold[NCH];
  logic [NCH-1:0] raw_v;

  initial begin
    rst_n = 1'b0;
    bus_if.en = 1'b1;
    bus_if.sensor_raw = '0;
    ticks(3);
    chk("reset_state",
        {bus_if.sens_stable, bus_if.arm_pulse, bus_if.trig_pulse, bus_if.conf_pulse}, 32'd0);
    rst_n = 1'b1;
    ticks(4);

    // 1: arm key rise, pulse after edge 5 only
    bus_if.sensor_raw = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 4) chk("t1_arm_before", bus_if.arm_pulse, 1'b0);
      if (k == 5) begin
        chk("t1_arm_at5", bus_if.arm_pulse, 1'b1);
        chk("t1_stable_at5", bus_if.sens_stable[0], 1'b1);
      end
      if (k == 6) chk("t1_arm_after", bus_if.arm_pulse, 1'b0);
    end
    bus_if.sensor_raw = 4'b0000;
    ticks(8);
    chk("t1_fall_no_pulse", arm_cnt, 32'd1);

    // 2: short glitch on ch1 is rejected
    t0 = trig_cnt;
    bus_if.sensor_raw = 4'b0010;
    ticks(3);
    bus_if.sensor_raw = 4'b0000;
    ticks(10);
    chk("t2_stable1", bus_if.sens_stable[1], 1'b0);
    chk("t2_no_trig", trig_cnt - t0, 32'd0);

    // 3: confirm pulse once per high period, re-arms after drop
    c0 = conf_cnt;
    bus_if.sensor_raw = 4'b0100;
    ticks(30);
    chk("t3_one_conf", conf_cnt - c0, 32'd1);
    bus_if.sensor_raw = 4'b0000;
    ticks(10);
    bus_if.sensor_raw = 4'b0100;
    ticks(30);
    chk("t3_second_conf", conf_cnt - c0, 32'd2);
    bus_if.sensor_raw = 4'b0000;
    ticks(10);

    // 4: en low suppresses pulses but not debouncing; en low mid-confirm restarts timer
    a0 = arm_cnt; t0 = trig_cnt; c0 = conf_cnt;
    bus_if.en = 1'b0;
    bus_if.sensor_raw = 4'b0011;
    ticks(12);
    chk("t4_stable_en0", bus_if.sens_stable[1:0], 2'b11);
    chk("t4_no_arm_trig", (arm_cnt - a0) + (trig_cnt - t0), 32'd0);
    bus_if.en = 1'b1;
    bus_if.sensor_raw = 4'b0100;
    ticks(10);
    bus_if.en = 1'b0;
    ticks(2);
    chk("t4_no_conf_mid", conf_cnt - c0, 32'd0);
    bus_if.en = 1'b1;
    ticks(12);
    chk("t4_conf_restart", conf_cnt - c0, 32'd1);
    bus_if.sensor_raw = 4'b0000;
    ticks(10);

    // 5: reset mid-debounce and mid-confirm, then full re-debounce
    bus_if.sensor_raw = 4'b1000;
    ticks(8);
    bus_if.sensor_raw = 4'b1001;
    ticks(3);
    async_reset_check("t5_async_rst_debounce");
    ticks(2);
    rst_n = 1'b1;
    a0 = arm_cnt;
    ticks(12);
    chk("t5_arm_after_rst", arm_cnt - a0, 32'd1);
    bus_if.sensor_raw = 4'b1101;
    ticks(8);
    async_reset_check("t5_async_rst_confirm");
    ticks(2);
    rst_n = 1'b1;
    c0 = conf_cnt;
    ticks(20);
    chk("t5_conf_after_rst", conf_cnt - c0, 32'd1);
    bus_if.sensor_raw = 4'b0000;
    ticks(10);

    // 6: simultaneous rises give simultaneous pulses
    b0 = both_cnt;
    bus_if.sensor_raw = 4'b0011;
    ticks(8);
    chk("t6_both_pulses", both_cnt - b0, 32'd1);
    bus_if.sensor_raw = 4'b0000;
    ticks(8);

    // Randomised phase: lines held for random durations, occasional en drop and reset
    raw_v = '0;
    for (int ch = 0; ch < NCH; ch++) hold[ch] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (hold[ch] == 0) begin
          raw_v[ch] = 1'($urandom_range(0, 1));
          hold[ch]  = int'($urandom_range(1, 14));
        end else begin
          hold[ch]--;
        end
      end
      bus_if.sensor_raw = raw_v;
      if (bus_if.en && $urandom_range(0, 99) == 0) bus_if.en = 1'b0;
      else if (!bus_if.en && $urandom_range(0, 9) == 0) bus_if.en = 1'b1;
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;
    ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
